// File: rtl/feistel_pkg.sv
// Shared types and round helpers for the Feistel cipher engine.
// Helpers work on a MAX_W-bit container; callers pass the live half width.
package feistel_pkg;

    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic logic [MAX_W-1:0] rotl(
        input logic [MAX_W-1:0] x,
        input int               n,
        input int               w
    );
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] v;
        m = (MAX_W'(1) << w) - MAX_W'(1);
        v = x & m;
        return ((v << n) | (v >> (w - n))) & m;
    endfunction

    function automatic logic [MAX_W-1:0] feistel_f(
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] k,
        input int               w
    );
        return (rotl(x, 1, w) & rotl(x, 8, w)) ^ rotl(x, 2, w) ^ k;
    endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational Feistel round, encrypt or decrypt direction.
module feistel_round
    import feistel_pkg::*;
#(
    parameter int HALF_W = 32
) (
    input  logic [2*HALF_W-1:0] blk_i,
    input  logic [HALF_W-1:0]   rk_i,
    input  logic                mode_i,
    output logic [2*HALF_W-1:0] blk_o
);

    logic [HALF_W-1:0] l;
    logic [HALF_W-1:0] r;
    logic [HALF_W-1:0] f_in;
    logic [HALF_W-1:0] f_out;

    assign l = blk_i[2*HALF_W-1 -: HALF_W];
    assign r = blk_i[HALF_W-1:0];

    // Decrypt feeds L through F so that it exactly undoes an encrypt round.
    assign f_in  = (mode_i == MODE_DEC) ? l : r;
    assign f_out = HALF_W'(feistel_f(MAX_W'(f_in), MAX_W'(rk_i), HALF_W));

    assign blk_o = (mode_i == MODE_DEC) ? {r ^ f_out, l}
                                        : {r, l ^ f_out};

endmodule

// File: rtl/feistel_cipher_core.sv
// Iterative Feistel engine: one round per clock, valid/ready on both sides.
module feistel_cipher_core
    import feistel_pkg::*;
#(
    parameter int HALF_W = 32,
    parameter int ROUNDS = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [2*HALF_W-1:0] in_block,
    input  logic [4*HALF_W-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_block
);

    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_e              state_q;
    logic [2*HALF_W-1:0] blk_q;
    logic [4*HALF_W-1:0] key_q;
    logic                mode_q;
    logic [CW-1:0]       idx_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [1:0]          ksel;
    logic [HALF_W-1:0]   kword;
    logic [HALF_W-1:0]   rk;
    logic [2*HALF_W-1:0] blk_d;
    logic                last_round;

    assign ksel = 2'(idx_q);

    always_comb begin
        kword = '0;
        case (ksel)
            2'd0:    kword = key_q[4*HALF_W-1 -: HALF_W];
            2'd1:    kword = key_q[3*HALF_W-1 -: HALF_W];
            2'd2:    kword = key_q[2*HALF_W-1 -: HALF_W];
            default: kword = key_q[HALF_W-1:0];
        endcase
    end

    assign rk = kword ^ HALF_W'(idx_q);

    feistel_round #(
        .HALF_W (HALF_W)
    ) u_round (
        .blk_i  (blk_q),
        .rk_i   (rk),
        .mode_i (mode_q),
        .blk_o  (blk_d)
    );

    assign last_round = (mode_q == MODE_DEC) ? (idx_q == '0)
                                             : (idx_q == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            key_q       <= '0;
            mode_q      <= MODE_ENC;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        blk_q      <= in_block;
                        key_q      <= in_key;
                        mode_q     <= in_mode;
                        idx_q      <= (in_mode == MODE_DEC) ? LAST : '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    blk_q <= blk_d;
                    if (last_round) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (mode_q == MODE_DEC) begin
                        idx_q <= idx_q - CW'(1);
                    end else begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_block = blk_q;

endmodule
